mem_trace_monitor: RTL and testbench

MEM_TRACE_MONITOR -- requirements
Module: mem_trace_monitor

---
 rtl/mem_trace_monitor.sv | 154 +++++++++++++++
 tb/tb_mem_trace_monitor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_trace_monitor.sv
// Bus trace monitor: captures data-region accesses (address bit 11 set) into a
// first-word-fall-through FIFO until the halt address is seen, then drains.
module mem_trace_monitor #(
    parameter int unsigned DEPTH         = 8,
    parameter bit          CAPTURE_READS = 1'b1,
    parameter logic [31:0] HALT_ADDR     = 32'h0000_0FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_we,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic        trace_is_write,
    output logic [7:0]  drop_count,
    output logic        halted,
    output logic        done
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e        state_q;
    logic          halted_q;
    logic          done_q;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    drop_q, drop_d;

    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic          wr_mem   [DEPTH];

    logic          hit_halt;
    logic          qualify;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          drop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Event qualification and FIFO handshake
    assign hit_halt   = (bus_address == HALT_ADDR);
    assign qualify    = (state_q == ST_RUN) && bus_address[11] && !hit_halt &&
                        (bus_we || CAPTURE_READS);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign pop        = !fifo_empty && trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push       = qualify && (!fifo_full || pop);
    assign drop       = qualify && fifo_full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (drop) begin
            drop_d = sat_inc8(drop_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Entry storage carries data only; validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= bus_address;
            data_mem[wr_ptr_q] <= bus_we ? bus_wdata : bus_rdata;
            wr_mem[wr_ptr_q]   <= bus_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (hit_halt) begin
                        state_q  <= ST_DRAIN;
                        halted_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Nothing is pushed while draining, so count_d alone tells emptiness.
                    if (count_d == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign trace_valid    = !fifo_empty;
    assign trace_addr     = fifo_empty ? 32'h0 : addr_mem[rd_ptr_q];
    assign trace_data     = fifo_empty ? 32'h0 : data_mem[rd_ptr_q];
    assign trace_is_write = fifo_empty ? 1'b0  : wr_mem[rd_ptr_q];
    assign drop_count     = drop_q;
    assign halted         = halted_q;
    assign done           = done_q;

endmodule

// File: tb/tb_mem_trace_monitor.sv
// Randomized bench for mem_trace_monitor: two instances (reads captured / not
// captured) compared each cycle against a queue-based reference model.
module tb_mem_trace_monitor;

    localparam int          DEPTH = 8;
    localparam logic [31:0] HALT  = 32'h0000_0FFC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bus_address;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_we;
    logic        trace_ready;

    logic        tvalid [2];
    logic [31:0] taddr  [2];
    logic [31:0] tdata  [2];
    logic        twr    [2];
    logic [7:0]  tdrop  [2];
    logic        thalt  [2];
    logic        tdone  [2];

    always #5 clk = ~clk;

    mem_trace_monitor #(.DEPTH(DEPTH), .CAPTURE_READS(1'b1), .HALT_ADDR(HALT)) u_dut_rd (
        .clk(clk), .reset(reset), .bus_address(bus_address), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_we(bus_we), .trace_valid(tvalid[0]),
        .trace_ready(trace_ready), .trace_addr(taddr[0]), .trace_data(tdata[0]),
        .trace_is_write(twr[0]), .drop_count(tdrop[0]), .halted(thalt[0]), .done(tdone[0])
    );

    mem_trace_monitor #(.DEPTH(DEPTH), .CAPTURE_READS(1'b0), .HALT_ADDR(HALT)) u_dut_wr (
        .clk(clk), .reset(reset), .bus_address(bus_address), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_we(bus_we), .trace_valid(tvalid[1]),
        .trace_ready(trace_ready), .trace_addr(taddr[1]), .trace_data(tdata[1]),
        .trace_is_write(twr[1]), .drop_count(tdrop[1]), .halted(thalt[1]), .done(tdone[1])
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
    } ent_t;

    // Reference model: per instance, a queue of entries, a drop tally and a phase
    // (0 tracing, 1 halted with entries left, 2 finished).
    ent_t mq     [2][$];
    int   mdrop  [2];
    int   mphase [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        ent_t e;
        int   ph;
        bit   qual;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mq[k].delete();
                mdrop[k]  = 0;
                mphase[k] = 0;
            end else begin
                ph = mphase[k];
                if (mq[k].size() > 0 && trace_ready) begin
                    void'(mq[k].pop_front());
                end
                qual = (ph == 0) && bus_address[11] && (bus_address != HALT) &&
                       (bus_we || (k == 0));
                if (qual) begin
                    if (mq[k].size() < DEPTH) begin
                        e.addr = bus_address;
                        e.data = bus_we ? bus_wdata : bus_rdata;
                        e.wr   = bus_we;
                        mq[k].push_back(e);
                    end else if (mdrop[k] < 255) begin
                        mdrop[k]++;
                    end
                end
                if (ph == 0 && bus_address == HALT) begin
                    mphase[k] = 1;
                end else if (ph == 1 && mq[k].size() == 0) begin
                    mphase[k] = 2;
                end
            end
        end
    endtask

    task automatic check_all();
        ent_t e;
        for (int k = 0; k < 2; k++) begin
            if (mq[k].size() > 0) begin
                e = mq[k][0];
                chk($sformatf("valid%0d", k), 32'(tvalid[k]), 32'd1);
                chk($sformatf("addr%0d", k), taddr[k], e.addr);
                chk($sformatf("data%0d", k), tdata[k], e.data);
                chk($sformatf("is_write%0d", k), 32'(twr[k]), 32'(e.wr));
            end else begin
                chk($sformatf("valid%0d", k), 32'(tvalid[k]), 32'd0);
                chk($sformatf("addr_idle%0d", k), taddr[k], 32'h0);
                chk($sformatf("data_idle%0d", k), tdata[k], 32'h0);
                chk($sformatf("is_write_idle%0d", k), 32'(twr[k]), 32'd0);
            end
            chk($sformatf("drop%0d", k), 32'(tdrop[k]), 32'(mdrop[k]));
            chk($sformatf("halted%0d", k), 32'(thalt[k]), 32'(mphase[k] != 0));
            chk($sformatf("done%0d", k), 32'(tdone[k]), 32'(mphase[k] == 2));
        end
    endtask

    task automatic drive(input logic rst, input logic [31:0] a, input logic we,
                         input logic [31:0] wd, input logic [31:0] rd, input logic rdy);
        reset       = rst;
        bus_address = a;
        bus_we      = we;
        bus_wdata   = wd;
        bus_rdata   = rd;
        trace_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, rdy);
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        int          rdy_pct;

        reset = 1'b1; bus_address = '0; bus_wdata = '0; bus_rdata = '0;
        bus_we = 1'b0; trace_ready = 1'b0;

        // Reset state
        drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("rst_valid", 32'(tvalid[0]), 32'd0);
        chk("rst_halted", 32'(thalt[0]), 32'd0);
        chk("rst_drop", 32'(tdrop[0]), 32'd0);

        // Single write, presented next cycle, popped at the following edge
        drive(1'b0, 32'h804, 1'b1, 32'hDEADBEEF, 32'h0, 1'b1);
        chk("wr1_addr", taddr[0], 32'h804);
        chk("wr1_data", tdata[0], 32'hDEADBEEF);
        chk("wr1_is_write", 32'(twr[0]), 32'd1);
        idle(1'b1);
        chk("wr1_popped", 32'(tvalid[0]), 32'd0);

        // Reads: bit 11 clear ignored, data-region read only when reads are captured
        drive(1'b0, 32'h7FC, 1'b0, 32'h0, 32'h55, 1'b0);
        drive(1'b0, 32'h900, 1'b0, 32'hAAAA, 32'h12, 1'b0);
        chk("rd_addr", taddr[0], 32'h900);
        chk("rd_data", tdata[0], 32'h12);
        chk("rd_is_write", 32'(twr[0]), 32'd0);
        chk("rd_nocap_valid", 32'(tvalid[1]), 32'd0);
        idle(1'b1);

        // Overflow: ten writes with the consumer stalled
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 32'h800 + 32'(4 * i), 1'b1, 32'hC0DE_0000 + 32'(i), 32'h0, 1'b0);
        end
        chk("ovf_drop", 32'(tdrop[0]), 32'd2);
        chk("ovf_head", taddr[0], 32'h800);

        // Full FIFO with pop and push together: no drop
        drive(1'b0, 32'h900, 1'b1, 32'h1234, 32'h0, 1'b1);
        chk("fullpp_drop", 32'(tdrop[0]), 32'd2);
        chk("fullpp_head", taddr[0], 32'h804);
        for (int i = 0; i < 9; i++) idle(1'b1);

        // Halt with two entries queued
        drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b0, 32'h800, 1'b1, 32'h1, 32'h0, 1'b0);
        drive(1'b0, 32'h804, 1'b1, 32'h2, 32'h0, 1'b0);
        drive(1'b0, HALT, 1'b1, 32'h3, 32'h0, 1'b0);
        chk("halt_halted", 32'(thalt[0]), 32'd1);
        chk("halt_done", 32'(tdone[0]), 32'd0);
        drive(1'b0, 32'h808, 1'b1, 32'h4, 32'h0, 1'b0);
        idle(1'b1);
        chk("halt_done_early", 32'(tdone[0]), 32'd0);
        idle(1'b1);
        chk("halt_done_final", 32'(tdone[0]), 32'd1);
        idle(1'b0);

        // Reset while draining with five entries
        drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 32'hA00 + 32'(4 * i), 1'b1, 32'(i), 32'h0, 1'b0);
        drive(1'b0, HALT, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 32'h810, 1'b1, 32'h77, 32'h0, 1'b0);
        chk("rstmid_valid", 32'(tvalid[0]), 32'd0);
        chk("rstmid_halted", 32'(thalt[0]), 32'd0);
        drive(1'b0, 32'h820, 1'b1, 32'h99, 32'h0, 1'b0);
        chk("rstmid_new", taddr[0], 32'h820);

        // Drop counter saturation
        for (int i = 0; i < 270; i++) drive(1'b0, 32'h800, 1'b1, 32'(i), 32'h0, 1'b0);
        chk("drop_sat", 32'(tdrop[0]), 32'hFF);
        drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Randomized traffic
        rdy_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) rdy_pct = int'($urandom_range(10, 95));
            sel = int'($urandom_range(0, 15));
            if (sel <= 9)       a = 32'h800 | ($urandom & 32'hFFFF_F7FC);
            else if (sel <= 12) a = $urandom & 32'hFFFF_F7FF;
            else if (sel == 13) a = ($urandom_range(0, 2) == 0) ? HALT : 32'h800;
            else                a = $urandom;
            drive((($urandom_range(0, 79) == 0) ||
                   (mphase[0] == 2 && mphase[1] == 2 && $urandom_range(0, 3) == 0)),
                  a, 1'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 99) < rdy_pct));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
